trng_health_sampler: RTL
========================

Name: trng_health_sampler

Overview:
Consumer side of the TRNG byte stream. Accepts raw 8-bit samples, runs continuous health tests on every sample (a repetition count test and an adaptive proportion test), and packs the samples into 32-bit words. Words go out through a valid/ready interface to the crypto/firmware reader. Any health failure blocks word output until software clears the alarm.

Parameters:
RCT_CUTOFF, 4, number of consecutive identical samples that raises rct_fail (range 2..255)
APT_WINDOW, 64, samples per adaptive-proportion window (range 2..256)
APT_CUTOFF, 13, occurrences of the window reference value within one window that raise apt_fail (range 2..APT_WINDOW)
WORD_BYTES, 4, samples per output word; output width is 8*WORD_BYTES

Ports:
clk  in  1  system clock
reset  in  1  reset, asynchronous, active-high
smp_valid  in  1  sample strobe; no backpressure to the source
smp_data  in  8  raw TRNG sample
word_valid  out  1  output word available
word_data  out  8*WORD_BYTES  packed word; first sample in bits [7:0]
word_ready  in  1  reader accepts the word
clear_alarm  in  1  single-cycle pulse; clears alarms and restarts tests and packing
rct_fail  out  1  sticky repetition-count failure
apt_fail  out  1  sticky adaptive-proportion failure
overflow  out  1  sticky; at least one sample was dropped from packing
health_ok  out  1  ~(rct_fail | apt_fail)

Behaviour:
- Reset: all outputs 0 except health_ok=1. Test counters, packer and output register are empty.
- Every cycle with smp_valid=1 is a sample. Health tests see every sample, including samples dropped from packing.
- RCT:
  - The first sample after reset or clear sets last=sample and rep_cnt=1.
  - Each later sample: if it equals last, rep_cnt increments (saturating at 255); otherwise rep_cnt=1 and last=sample.
  - When rep_cnt reaches RCT_CUTOFF, rct_fail=1 on the following edge.
- APT:
  - The first sample of a window becomes ref, with cnt=1 and idx=1.
  - Each later sample in the window increments idx, and increments cnt when sample==ref.
  - When cnt reaches APT_CUTOFF, apt_fail=1 on the following edge.
  - After idx reaches APT_WINDOW, the next sample starts a new window.
- Packer: a byte-lane shift register with count 0..WORD_BYTES-1. Samples fill lanes 0,1,2,3 in order.
- Completing a word (sample in lane WORD_BYTES-1):
  - If the output register is empty, or is consumed this cycle (word_valid & word_ready), the word loads into the output register at that edge. word_valid=1 from the next cycle, so latency is 1 cycle after the last sample.
  - Otherwise the word stays in the packer (pack_full). It moves to the output register on the edge of the next handshake, so word_valid stays high without a bubble.
- While pack_full=1 and output is full, incoming samples are dropped from packing and overflow=1. Tests still run on those samples.
- Handshake: transfer on word_valid & word_ready. word_data is stable while word_valid & ~word_ready. With no replacement word, word_valid deasserts the cycle after transfer.
- Alarm:
  - When rct_fail or apt_fail becomes 1, the output register and packer are invalidated on the same edge. word_valid=0 from the next cycle.
  - A handshake in the cycle the fail is detected still completes and counts as transferred.
  - While health_ok=0, samples update the tests but are not packed.
- clear_alarm:
  - Clears rct_fail, apt_fail and overflow.
  - Restarts both tests (next sample is treated as the first) and empties the packer and output register.
  - If clear_alarm and a failure trigger occur in the same cycle, clear wins.
  - If a sample arrives in the clear cycle, it is discarded.
- Reset mid-word discards partial data; no partial word is ever emitted.

Decomposition:
- Package trng_pkg:
  - TRNG_SMP_W=8.
  - Default RCT_CUTOFF, APT_WINDOW and APT_CUTOFF constants.
  - Counter widths derived with $clog2.
- Sub-module trng_health_tests:
  - Contains RCT and APT, with inputs clk, reset, clear, smp_valid, smp_data and outputs rct_hit, apt_hit.
  - The top level owns the sticky flags, packer, output register and handshake.

Test Plan:
1. Packing: samples 11,22,33,44 with word_ready=1 -> word_data=32'h44332211 and word_valid=1 one cycle after the 44 sample, for exactly 1 cycle.
2. Backpressure/overflow: word_ready=0 and 12 distinct samples -> word0 held stable, word1 in packer, samples 9..12 dropped, overflow=1. Raising word_ready gives word0 then word1 on consecutive cycles.
3. RCT: samples A5,A5,A5,A5 with RCT_CUTOFF=4 -> rct_fail=1 the cycle after the 4th, word_valid forced 0, health_ok=0. Samples A5,A5,A5,3C -> no failure.
4. APT: 64-sample window with ref 7E occurring 13 times -> apt_fail=1 after the 13th occurrence. 12 occurrences, then a new window with 12 occurrences -> no failure.
5. Recovery: assert clear_alarm after test 3 -> flags 0, then 4 distinct samples -> normal word output. clear_alarm coincident with a failure trigger -> flag stays 0.
6. Reset mid-word: 2 samples, assert reset, then 4 samples -> the only word emitted contains the post-reset samples, and all sticky flags are 0.

Source files
------------

// File: rtl/trng_pkg.sv
// Shared constants and helpers for the TRNG sample consumer.
// Counter widths are sized for the largest legal cutoff/window values.
package trng_pkg;

  localparam int TRNG_SMP_W = 8;

  localparam int RCT_CUTOFF_DEF = 4;
  localparam int APT_WINDOW_DEF = 64;
  localparam int APT_CUTOFF_DEF = 13;
  localparam int WORD_BYTES_DEF = 4;

  // RCT counter saturates at 255; APT counters must hold a full 256-sample window.
  localparam int RCT_CNT_MAX = 255;
  localparam int RCT_CNT_W   = $clog2(RCT_CNT_MAX + 1);
  localparam int APT_MAX_WIN = 256;
  localparam int APT_CNT_W   = $clog2(APT_MAX_WIN + 1);

  function automatic logic [RCT_CNT_W-1:0] rct_sat_inc(input logic [RCT_CNT_W-1:0] v);
    logic [RCT_CNT_W-1:0] r;
    r = v;
    if (v != RCT_CNT_W'(RCT_CNT_MAX)) begin
      r = v + RCT_CNT_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/trng_health_tests.sv
// Repetition-count and adaptive-proportion tests on the raw sample stream.
// Hits are combinational with the sample that reaches the cutoff; clear discards that cycle's sample.
module trng_health_tests
  import trng_pkg::*;
#(
  parameter int RCT_CUTOFF = RCT_CUTOFF_DEF,
  parameter int APT_WINDOW = APT_WINDOW_DEF,
  parameter int APT_CUTOFF = APT_CUTOFF_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  smp_valid,
  input  logic [TRNG_SMP_W-1:0] smp_data,
  output logic                  rct_hit,
  output logic                  apt_hit
);

  localparam logic [RCT_CNT_W-1:0] RCT_LIM = RCT_CNT_W'(RCT_CUTOFF);
  localparam logic [APT_CNT_W-1:0] APT_LIM = APT_CNT_W'(APT_CUTOFF);
  localparam logic [APT_CNT_W-1:0] APT_WIN = APT_CNT_W'(APT_WINDOW);

  logic                  rct_started;
  logic [TRNG_SMP_W-1:0] rct_last;
  logic [RCT_CNT_W-1:0]  rep_cnt;
  logic [RCT_CNT_W-1:0]  rep_next;

  logic                  apt_started;
  logic [TRNG_SMP_W-1:0] apt_ref;
  logic [APT_CNT_W-1:0]  apt_cnt;
  logic [APT_CNT_W-1:0]  apt_idx;
  logic [APT_CNT_W-1:0]  apt_cnt_next;
  logic [APT_CNT_W-1:0]  apt_idx_next;
  logic                  new_win;
  logic                  take;

  assign take = smp_valid & ~clear;

  always_comb begin
    rep_next     = rep_cnt;
    new_win      = 1'b0;
    apt_cnt_next = apt_cnt;
    apt_idx_next = apt_idx;

    if (!rct_started || (smp_data != rct_last)) begin
      rep_next = RCT_CNT_W'(1);
    end else begin
      rep_next = rct_sat_inc(rep_cnt);
    end

    // A window closes once idx has counted APT_WINDOW samples.
    new_win = !apt_started || (apt_idx == APT_WIN);
    if (new_win) begin
      apt_cnt_next = APT_CNT_W'(1);
      apt_idx_next = APT_CNT_W'(1);
    end else begin
      apt_idx_next = apt_idx + APT_CNT_W'(1);
      apt_cnt_next = (smp_data == apt_ref) ? apt_cnt + APT_CNT_W'(1) : apt_cnt;
    end
  end

  assign rct_hit = take && (rep_next >= RCT_LIM);
  assign apt_hit = take && (apt_cnt_next >= APT_LIM);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rct_started <= 1'b0;
      rct_last    <= '0;
      rep_cnt     <= '0;
      apt_started <= 1'b0;
      apt_ref     <= '0;
      apt_cnt     <= '0;
      apt_idx     <= '0;
    end else if (clear) begin
      rct_started <= 1'b0;
      rct_last    <= '0;
      rep_cnt     <= '0;
      apt_started <= 1'b0;
      apt_ref     <= '0;
      apt_cnt     <= '0;
      apt_idx     <= '0;
    end else if (smp_valid) begin
      rct_started <= 1'b1;
      rct_last    <= smp_data;
      rep_cnt     <= rep_next;
      apt_started <= 1'b1;
      apt_cnt     <= apt_cnt_next;
      apt_idx     <= apt_idx_next;
      if (new_win) begin
        apt_ref <= smp_data;
      end
    end
  end

endmodule

// File: rtl/trng_health_sampler.sv
// Health-tests every TRNG sample and packs them into words behind a valid/ready port.
// One-cycle pack latency; a second finished word waits in the packer, later samples are dropped.
module trng_health_sampler
  import trng_pkg::*;
#(
  parameter int RCT_CUTOFF = RCT_CUTOFF_DEF,
  parameter int APT_WINDOW = APT_WINDOW_DEF,
  parameter int APT_CUTOFF = APT_CUTOFF_DEF,
  parameter int WORD_BYTES = WORD_BYTES_DEF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             smp_valid,
  input  logic [TRNG_SMP_W-1:0]            smp_data,
  output logic                             word_valid,
  output logic [TRNG_SMP_W*WORD_BYTES-1:0] word_data,
  input  logic                             word_ready,
  input  logic                             clear_alarm,
  output logic                             rct_fail,
  output logic                             apt_fail,
  output logic                             overflow,
  output logic                             health_ok
);

  localparam int WORD_W = TRNG_SMP_W * WORD_BYTES;
  localparam int PCNT_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [PCNT_W-1:0] LAST_LANE = PCNT_W'(WORD_BYTES - 1);

  logic              rct_hit;
  logic              apt_hit;
  logic [WORD_W-1:0] pack_data;
  logic [PCNT_W-1:0] pack_cnt;
  logic              pack_full;
  logic [WORD_W-1:0] out_data;
  logic              out_vld;

  logic              xfer;
  logic              kill;
  logic              accept;
  logic              drop;
  logic              word_done;
  logic [WORD_W-1:0] shifted;

  trng_health_tests #(
    .RCT_CUTOFF (RCT_CUTOFF),
    .APT_WINDOW (APT_WINDOW),
    .APT_CUTOFF (APT_CUTOFF)
  ) u_tests (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear_alarm),
    .smp_valid (smp_valid),
    .smp_data  (smp_data),
    .rct_hit   (rct_hit),
    .apt_hit   (apt_hit)
  );

  // New samples enter the top lane, so the first sample lands in [7:0] once the word is full.
  assign shifted = {smp_data, pack_data[WORD_W-1:TRNG_SMP_W]};

  assign xfer      = out_vld & word_ready;
  assign kill      = clear_alarm | rct_hit | apt_hit;
  assign accept    = smp_valid & ~kill & health_ok & ~(pack_full & out_vld);
  assign drop      = smp_valid & ~kill & health_ok & pack_full & out_vld;
  assign word_done = accept & (pack_cnt == LAST_LANE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rct_fail <= 1'b0;
      apt_fail <= 1'b0;
      overflow <= 1'b0;
    end else if (clear_alarm) begin
      rct_fail <= 1'b0;
      apt_fail <= 1'b0;
      overflow <= 1'b0;
    end else begin
      rct_fail <= rct_fail | rct_hit;
      apt_fail <= apt_fail | apt_hit;
      overflow <= overflow | drop;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pack_data <= '0;
      pack_cnt  <= '0;
      pack_full <= 1'b0;
      out_data  <= '0;
      out_vld   <= 1'b0;
    end else if (kill) begin
      // A handshake in this cycle still completes; nothing buffered survives an alarm or clear.
      pack_cnt  <= '0;
      pack_full <= 1'b0;
      out_vld   <= 1'b0;
    end else begin
      if (xfer) begin
        out_vld <= 1'b0;
      end
      if (pack_full && xfer) begin
        out_data  <= pack_data;
        out_vld   <= 1'b1;
        pack_full <= 1'b0;
      end
      // accept implies the packer is not holding a finished word.
      if (accept) begin
        pack_data <= shifted;
        if (word_done) begin
          pack_cnt <= '0;
          if (!out_vld || xfer) begin
            out_data <= shifted;
            out_vld  <= 1'b1;
          end else begin
            pack_full <= 1'b1;
          end
        end else begin
          pack_cnt <= pack_cnt + PCNT_W'(1);
        end
      end
    end
  end

  assign word_valid = out_vld;
  assign word_data  = out_data;
  assign health_ok  = ~(rct_fail | apt_fail);

endmodule
